// File: rtl/alu_shift_pkg.sv
// Shared definitions for the iterative shift units: state encoding, default widths and the
// chunk-size helper used when ITER_SLL_FAST_EN is defined.
package alu_shift_pkg;

   localparam int unsigned SllWidth  = 32;
   localparam int unsigned SllShamtW = 5;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
   localparam logic [1:0] StDone  = 2'd2;

   // Largest power of two not exceeding count; 0 when count is 0.
   function automatic int unsigned pow2_floor(input int unsigned count);
      int unsigned p;
      p = 0;
      for (int i = 31; i >= 0; i--) begin
         if (p == 0 && count[i]) p = 32'd1 << i;
      end
      return p;
   endfunction

endpackage

// File: rtl/sll_1.sv
// Single-step logical shift-left cell, the mirror of the single-step right-shift cell.
module sll_1
   import alu_shift_pkg::*;
#(
   parameter int unsigned WIDTH = SllWidth
) (
   input  logic [WIDTH-1:0] a_i,
   output logic [WIDTH-1:0] y_o
);

   assign y_o = {a_i[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/iter_sll.sv
// Multi-cycle logical shift-left with start/done handshake.
// ITER_SLL_FAST_EN: shift by power-of-two chunks instead of one bit per clock.
module iter_sll
   import alu_shift_pkg::*;
#(
   parameter int unsigned WIDTH   = SllWidth,
   parameter int unsigned SHAMT_W = SllShamtW
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result,
   output logic               lost
);

   logic [1:0]         state_q, state_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0] count_q, count_d;
   logic               acc_q, acc_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               lost_q, lost_d;

   logic [WIDTH-1:0]   step_val;
   logic               step_lost;
   logic [SHAMT_W-1:0] count_nxt;

`ifdef ITER_SLL_FAST_EN
   int unsigned chunk;

   always_comb begin
      chunk     = pow2_floor(32'(count_q));
      step_val  = work_q << chunk;
      step_lost = |(work_q & ~({WIDTH{1'b1}} >> chunk));
      count_nxt = count_q - SHAMT_W'(chunk);
   end
`else
   localparam logic [SHAMT_W-1:0] CountOne = SHAMT_W'(1);

   logic [WIDTH-1:0] sll_out;

   sll_1 #(
      .WIDTH (WIDTH)
   ) u_sll_1 (
      .a_i (work_q),
      .y_o (sll_out)
   );

   always_comb begin
      step_val  = sll_out;
      step_lost = work_q[WIDTH-1];
      count_nxt = count_q - CountOne;
   end
`endif

   // acc_q collects shifted-out bits in flight; lost_q only updates on the final step.
   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      count_d  = count_q;
      acc_d    = acc_q;
      result_d = result_q;
      lost_d   = lost_q;
      case (state_q)
         StShift: begin
            work_d  = step_val;
            count_d = count_nxt;
            acc_d   = acc_q | step_lost;
            if (count_nxt == '0) begin
               state_d  = StDone;
               result_d = step_val;
               lost_d   = acc_q | step_lost;
            end
         end
         default: begin
            state_d = StIdle;
            if (start) begin
               work_d  = data_in;
               count_d = shamt;
               acc_d   = 1'b0;
               if (shamt == '0) begin
                  state_d  = StDone;
                  result_d = data_in;
                  lost_d   = 1'b0;
               end else begin
                  state_d = StShift;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         work_q   <= '0;
         count_q  <= '0;
         acc_q    <= 1'b0;
         result_q <= '0;
         lost_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         lost_q   <= lost_d;
      end
   end

   assign ready  = (state_q == StIdle) || (state_q == StDone);
   assign busy   = (state_q == StShift);
   assign done   = (state_q == StDone);
   assign result = result_q;
   assign lost   = lost_q;

endmodule

// File: tb/tb_iter_sll.sv
// Self-checking bench for iter_sll: directed table, handshake corner cases and random ops.
module tb_iter_sll;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] data_in = '0;
   logic [4:0]  shamt = '0;
   logic        ready, busy, done, lost;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   iter_sll #(
      .WIDTH   (32),
      .SHAMT_W (5)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .data_in (data_in),
      .shamt   (shamt),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .lost    (lost)
   );

   typedef struct {
      logic [31:0] d;
      logic [4:0]  sh;
      logic [31:0] res;
      logic        lst;
      int          lat_slow;
      int          lat_fast;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic [4:0] sh);
`ifdef ITER_SLL_FAST_EN
      return $countones(sh) + 1;
`else
      return int'(sh) + 1;
`endif
   endfunction

   // Reference: widen to 64 bits, shift, anything landing above bit 31 was lost.
   function automatic logic [32:0] model(input logic [31:0] d, input logic [4:0] sh);
      logic [63:0] wide;
      wide = {32'b0, d} << sh;
      return {|wide[63:32], wide[31:0]};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic launch(input logic [31:0] d, input logic [4:0] sh);
      start   = 1'b1;
      data_in = d;
      shamt   = sh;
      step();
      start   = 1'b0;
      data_in = $urandom;
      shamt   = 5'($urandom);
   endtask

   // Called in the cycle after an edge; lat counts that cycle as 1.
   task automatic wait_done(output int lat, output int busy_n, output bit seen);
      lat    = 1;
      busy_n = 0;
      seen   = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busy_n++;
         step();
         lat++;
      end
   endtask

   task automatic run_op(input string name, input logic [31:0] d, input logic [4:0] sh,
                         input logic [31:0] exp_res, input logic exp_lost, input int exp_l);
      int  lat, busy_n;
      bit  seen;
      launch(d, sh);
      wait_done(lat, busy_n, seen);
      check({name, " done"}, 64'(seen), 64'd1);
      check({name, " latency"}, 64'(lat), 64'(exp_l));
      check({name, " busy cycles"}, 64'(busy_n), 64'(exp_l - 1));
      check({name, " result"}, 64'(result), 64'(exp_res));
      check({name, " lost"}, 64'(lost), 64'(exp_lost));
   endtask

   initial begin
      vec_t vecs[6];
      int   lat, busy_n, ndone;
      bit   seen;
      logic [32:0] m;
      logic [31:0] rd;
      logic [4:0]  rs;

      vecs[0] = '{32'h0000_0001, 5'd4,  32'h0000_0010, 1'b0, 5,  2};
      vecs[1] = '{32'h8000_0003, 5'd1,  32'h0000_0006, 1'b1, 2,  2};
      vecs[2] = '{32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1,  1};
      vecs[3] = '{32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b1, 32, 6};
      vecs[4] = '{32'h0000_FFFF, 5'd16, 32'hFFFF_0000, 1'b0, 17, 2};
      vecs[5] = '{32'h0001_0000, 5'd16, 32'h0000_0000, 1'b1, 17, 2};

      // Reset state
      #12;
      check("rst ready", 64'(ready), 64'd1);
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst result", 64'(result), 64'd0);
      check("rst lost", 64'(lost), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      step();

      foreach (vecs[i]) begin
`ifdef ITER_SLL_FAST_EN
         run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].sh, vecs[i].res, vecs[i].lst,
                vecs[i].lat_fast);
`else
         run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].sh, vecs[i].res, vecs[i].lst,
                vecs[i].lat_slow);
`endif
         step();
         check($sformatf("vec%0d idle done", i), 64'(done), 64'd0);
         check($sformatf("vec%0d idle ready", i), 64'(ready), 64'd1);
         check($sformatf("vec%0d held result", i), 64'(result), 64'(vecs[i].res));
      end

      // start during SHIFT is ignored
      launch(32'h1, 5'd7);
      step();
      start   = 1'b1;
      data_in = 32'h0000_00FF;
      shamt   = 5'd1;
      step();
      start = 1'b0;
      wait_done(lat, busy_n, seen);
      check("ignore done", 64'(seen), 64'd1);
      check("ignore latency", 64'(lat + 2), 64'(exp_lat(5'd7)));
      check("ignore result", 64'(result), 64'h80);
      check("ignore lost", 64'(lost), 64'd0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done) ndone++;
      end
      check("ignore no second done", 64'(ndone), 64'd0);

      // back-to-back start in the DONE cycle
      launch(32'h3, 5'd1);
      wait_done(lat, busy_n, seen);
      check("b2b first result", 64'(result), 64'h6);
      check("b2b ready in done", 64'(ready), 64'd1);
      launch(32'h1, 5'd2);
      check("b2b busy after accept", 64'(busy), 64'd1);
      wait_done(lat, busy_n, seen);
      check("b2b second done", 64'(seen), 64'd1);
      check("b2b second latency", 64'(lat), 64'(exp_lat(5'd2)));
      check("b2b second result", 64'(result), 64'h4);

      // asynchronous reset mid-SHIFT
      launch(32'hFFFF_FFFF, 5'd31);
      step();
      #2;
      reset = 1'b1;
      #1;
      check("arst ready", 64'(ready), 64'd1);
      check("arst busy", 64'(busy), 64'd0);
      check("arst done", 64'(done), 64'd0);
      check("arst result", 64'(result), 64'd0);
      check("arst lost", 64'(lost), 64'd0);
      #1;
      reset = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (done || busy) ndone++;
      end
      check("arst no activity", 64'(ndone), 64'd0);
      run_op("after arst", 32'h0000_0005, 5'd3, 32'h0000_0028, 1'b0, exp_lat(5'd3));

      // random operations against the reference model
      for (int i = 0; i < 40; i++) begin
         rd = $urandom;
         rs = 5'($urandom_range(0, 31));
         if (i % 8 == 0) rd = 32'hFFFF_FFFF;
         m = model(rd, rs);
         run_op($sformatf("rnd%0d d=%h sh=%0d", i, rd, rs), rd, rs, m[31:0], m[32],
                exp_lat(rs));
         if (i % 3 == 0) step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
